// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - column-serial AES InvMixColumns engine
// Accepts one 128-bit state, transforms COLS_PER_CYCLE columns per clock, holds the result until taken.
module inv_mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] b_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] b_out
);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
         $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       state, state_next;
   logic [1:0]   col_cnt, col_cnt_next;
   logic [127:0] src_reg;
   logic [31:0]  src_cols [4];
   logic [31:0]  res_cols [4];
   logic [1:0]   col_idx  [COLS_PER_CYCLE];
   logic [31:0]  mixed    [COLS_PER_CYCLE];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] s [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         s[i]  = col[31-8*i -: 8];
         x2[i] = xtime(s[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ s[i];
         mb[i] = x8[i] ^ x2[i] ^ s[i];
         md[i] = x8[i] ^ x4[i] ^ s[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         src_cols[c] = src_reg[127-32*c -: 32];
      end
      // Only COLS_PER_CYCLE column units exist; they are steered onto the current column group.
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         col_idx[k] = col_cnt + 2'(k);
         mixed[k]   = inv_mix_col(src_cols[col_idx[k]]);
      end
   end

   assign b_out = {res_cols[0], res_cols[1], res_cols[2], res_cols[3]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         col_cnt <= 2'd0;
      end else begin
         state   <= state_next;
         col_cnt <= col_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      col_cnt_next = col_cnt;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next   = BUSY;
               col_cnt_next = 2'd0;
            end
         end
         BUSY: begin
            if (col_cnt == LAST_CNT) begin
               state_next   = DONE;
               col_cnt_next = 2'd0;
            end else begin
               col_cnt_next = col_cnt + STEP;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next   = IDLE;
            col_cnt_next = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_reg <= '0;
         for (int c = 0; c < 4; c++) begin
            res_cols[c] <= '0;
         end
      end else begin
         if (state == IDLE && in_valid) begin
            src_reg <= b_in;
         end
         if (state == BUSY) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
               res_cols[col_idx[k]] <= mixed[k];
            end
         end
      end
   end

endmodule
